// File: rtl/mips_multicycle.sv
// Multicycle MIPS-style core: FETCH/DECODE/EXECUTE/WRITEBACK FSM with req/ready instruction fetch.
// Define MIPS_PERF_CNT_EN to build the cycle and retired-instruction counters.
module mips_multicycle #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       REG_AW   = 6,
  parameter int unsigned       INSTR_W  = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               retire,
  output logic               illegal,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        ret_cnt
);
  localparam int unsigned IMM_W = INSTR_W - 6 - 2 * REG_AW;

  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpSub  = 6'h02;
  localparam logic [5:0] OpAnd  = 6'h03;
  localparam logic [5:0] OpOr   = 6'h04;
  localparam logic [5:0] OpSlt  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h06;
  localparam logic [5:0] OpBeq  = 6'h07;
  localparam logic [5:0] OpHalt = 6'h08;

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StWriteback, StHalted} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   a_q, b_q, r_q;
  logic                zero_q, req_q, retire_q, illegal_q, halted_q;
  logic [DATA_W-1:0]   rf [2**REG_AW];

  logic [5:0]          op;
  logic [REG_AW-1:0]   rd, rs, rt;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_ext, rf_rs, rf_rt, rf_rd, alu_res;
  logic                wb_en;

  assign op  = ir_q[5:0];
  assign rd  = ir_q[6 +: REG_AW];
  assign rs  = ir_q[6 + REG_AW +: REG_AW];
  assign rt  = ir_q[6 + 2 * REG_AW +: REG_AW];
  assign imm = ir_q[INSTR_W-1 -: IMM_W];

  if (IMM_W >= DATA_W) begin : g_imm_trunc
    assign imm_ext = imm[DATA_W-1:0];
  end else begin : g_imm_sext
    assign imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  end

  // r0 is never written, but the read side forces zero so its storage value is irrelevant.
  assign rf_rs     = (rs == '0) ? '0 : rf[rs];
  assign rf_rt     = (rt == '0) ? '0 : rf[rt];
  assign rf_rd     = (rd == '0) ? '0 : rf[rd];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];
  assign wb_en     = (op >= OpAdd) && (op <= OpAddi);

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a_q + b_q;
      OpSub:   alu_res = a_q - b_q;
      OpAnd:   alu_res = a_q & b_q;
      OpOr:    alu_res = a_q | b_q;
      OpSlt:   alu_res = {{(DATA_W - 1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OpAddi:  alu_res = a_q + imm_ext;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == StWriteback && wb_en && rd != '0) begin
      rf[rd] <= r_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      zero_q    <= 1'b0;
      req_q     <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        StFetch: begin
          // req is registered, so the first FETCH after reset spends one cycle raising it.
          if (req_q && imem_ready) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= StDecode;
          end else begin
            req_q <= 1'b1;
          end
        end
        StDecode: begin
          a_q     <= rf_rs;
          b_q     <= (op == OpBeq) ? rf_rd : rf_rt;
          state_q <= StExecute;
        end
        StExecute: begin
          r_q       <= alu_res;
          zero_q    <= (a_q == b_q);
          retire_q  <= (op != OpHalt);
          illegal_q <= (op > OpHalt);
          state_q   <= StWriteback;
        end
        StWriteback: begin
          if (op == OpHalt) begin
            halted_q <= 1'b1;
            state_q  <= StHalted;
          end else begin
            pc_q    <= (op == OpBeq && zero_q) ? imm[ADDR_W-1:0]
                                               : pc_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
            req_q   <= 1'b1;
            state_q <= StFetch;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StFetch;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign retire    = retire_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (!halted_q) cyc_q <= cyc_q + 32'd1;
      if (retire_q)  ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: ISA-level model with per-cycle compare, plus directed literal checks.
module tb_mips_multicycle;
  localparam logic [15:0] RstPc = 16'h0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr, pc_out;
  logic [63:0] imem_rdata, dbg_rdata;
  logic        retire, illegal, halted;
  logic [5:0]  dbg_raddr;
  logic [31:0] cyc_cnt, ret_cnt;
  logic [63:0] prog [256];

  assign imem_rdata = prog[imem_addr[7:0]];

  mips_multicycle dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .retire     (retire),
    .illegal    (illegal),
    .halted     (halted),
    .pc_out     (pc_out),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
  );

  // Narrow-PC instance running NOPs from pc 15 to exercise wrap-around.
  logic        w_req, w_ready, w_retire, w_illegal, w_halted;
  logic [3:0]  w_addr, w_pc;
  logic [63:0] w_rdata, w_dbg_rdata;
  logic [5:0]  w_dbg_raddr;
  logic [31:0] w_cyc, w_ret;

  mips_multicycle #(.ADDR_W(4), .RESET_PC(4'hF)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_ready (w_ready),
    .imem_rdata (w_rdata),
    .retire     (w_retire),
    .illegal    (w_illegal),
    .halted     (w_halted),
    .pc_out     (w_pc),
    .dbg_raddr  (w_dbg_raddr),
    .dbg_rdata  (w_dbg_rdata),
    .cyc_cnt    (w_cyc),
    .ret_cnt    (w_ret)
  );

  int nchecks = 0;
  int nerr    = 0;
  int stall_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [63:0] mreg [64];
  bit          mvalid [64];
  logic [15:0] mpc;
  bit          mhalted, busy, prev_wait;
  int          cnt, cyc, ill_cnt;
  logic [63:0] cur;
  int          ret_times [$];

  function automatic logic [63:0] rv(input logic [5:0] a);
    return (a == 6'd0) ? 64'd0 : mreg[a];
  endfunction

  task automatic wr(input logic [5:0] a, input logic [63:0] v);
    if (a != 6'd0) begin
      mreg[a]   = v;
      mvalid[a] = 1'b1;
    end
  endtask

  task automatic model_exec(input logic [63:0] ins);
    logic [5:0]  op, rd, rs, rt;
    logic [63:0] imm, a, b;
    logic [15:0] nxt;
    op  = ins[5:0];
    rd  = ins[11:6];
    rs  = ins[17:12];
    rt  = ins[23:18];
    imm = $signed(ins) >>> 18;
    a   = rv(rs);
    b   = rv(rt);
    nxt = mpc + 16'd1;
    case (op)
      6'h01: wr(rd, a + b);
      6'h02: wr(rd, a - b);
      6'h03: wr(rd, a & b);
      6'h04: wr(rd, a | b);
      6'h05: wr(rd, ($signed(a) < $signed(b)) ? 64'd1 : 64'd0);
      6'h06: wr(rd, a + imm);
      6'h07: if (a == rv(rd)) nxt = ins[33:18];
      6'h08: begin
        mhalted = 1'b1;
        nxt     = mpc;
      end
      default: ;
    endcase
    mpc = nxt;
  endtask

  // Fetch handshake -> three more cycles -> retire; state becomes visible the cycle after.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mpc       = RstPc;
      mhalted   = 1'b0;
      busy      = 1'b0;
      cnt       = 0;
      prev_wait = 1'b0;
    end else begin
      check("pc_out", pc_out, mpc);
      check("halted", halted, mhalted);
      check("retire", retire, busy && cnt == 0 && cur[5:0] != 6'h08);
      check("illegal", illegal, busy && cnt == 0 && cur[5:0] > 6'h08);
      if (busy || mhalted) check("req_idle", imem_req, 64'd0);
      if (prev_wait) check("req_hold", imem_req, 64'd1);
      if (imem_req === 1'b1) check("imem_addr", imem_addr, mpc);
      if (mvalid[dbg_raddr]) check("dbg_rdata", dbg_rdata, rv(dbg_raddr));
      if (retire === 1'b1) ret_times.push_back(cyc);
      if (illegal === 1'b1 && retire === 1'b1) ill_cnt++;
      if (busy) begin
        if (cnt == 0) begin
          model_exec(cur);
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req === 1'b1 && imem_ready === 1'b1) begin
        cur  = prog[mpc[7:0]];
        busy = 1'b1;
        cnt  = 2;
      end
      prev_wait = (imem_req === 1'b1) && (imem_ready !== 1'b1);
    end
  end

  // Instruction memory: stall_n not-ready cycles at the start of every request.
  initial begin
    int waited;
    waited     = 0;
    imem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        imem_ready = (waited >= stall_n);
        waited++;
      end else begin
        imem_ready = 1'b0;
        waited     = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", nchecks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] enc(input logic [5:0] op, input logic [5:0] rd,
                                      input logic [5:0] rs, input longint imm);
    logic [63:0] v;
    v = imm;
    return {v[45:0], rs, rd, op};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) prog[i] = 64'd0;
    ret_times.delete();
    ill_cnt = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      dbg_raddr = 6'(n % 8);
      n++;
    end
    check("halt_reached", halted, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reg(input string name, input logic [5:0] a, input logic [63:0] exp);
    dbg_raddr = a;
    #1;
    check(name, dbg_rdata, exp);
  endtask

  task automatic load_prog_a();
    prog[0] = enc(6'h06, 6'd1, 6'd0, 5);
    prog[1] = enc(6'h06, 6'd2, 6'd0, -3);
    prog[2] = enc(6'h01, 6'd3, 6'd1, 2);
    prog[3] = enc(6'h02, 6'd4, 6'd1, 2);
    prog[4] = enc(6'h08, 6'd0, 6'd0, 0);
  endtask

  task automatic check_prog_a(input int period);
    check_reg("a_r1", 6'd1, 64'd5);
    check_reg("a_r2", 6'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    check_reg("a_r3", 6'd3, 64'd2);
    check_reg("a_r4", 6'd4, 64'd8);
    check("a_pc", pc_out, 64'd4);
    check("a_retires", ret_times.size(), 64'd4);
    if (ret_times.size() >= 4) begin
      check("a_period01", ret_times[1] - ret_times[0], period);
      check("a_period23", ret_times[3] - ret_times[2], period);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n       = 1'b0;
    dbg_raddr   = 6'd0;
    w_dbg_raddr = 6'd0;
    w_ready     = 1'b1;
    w_rdata     = 64'd0;
    cyc         = 0;
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = (i == 0);
      mreg[i]   = 64'd0;
    end

    // Reset state and PC wrap on the narrow instance.
    do_reset();
    #1;
    check("rst_req", imem_req, 64'd0);
    check("rst_pc", pc_out, RstPc);
    check("rst_retire", retire, 64'd0);
    check("rst_halted", halted, 64'd0);
    release_reset();
    #1;
    check("w_pc_reset", w_pc, 64'hF);
    n = 0;
    while (w_retire !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w_retire_seen", w_retire, 64'd1);
    check("w_pc_before_wrap", w_pc, 64'hF);
    @(negedge clk);
    check("w_pc_wrapped", w_pc, 64'd0);

    // Arithmetic program, no stalls.
    do_reset();
    stall_n = 0;
    load_prog_a();
    release_reset();
    run_to_halt(200);
    check_prog_a(4);

    // Clear r3/r4, then same program with three stall cycles per fetch.
    do_reset();
    prog[0] = enc(6'h06, 6'd3, 6'd0, 0);
    prog[1] = enc(6'h06, 6'd4, 6'd0, 0);
    prog[2] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    run_to_halt(200);
    check_reg("clr_r3", 6'd3, 64'd0);
    do_reset();
    stall_n = 3;
    load_prog_a();
    release_reset();
    run_to_halt(300);
    check_prog_a(7);
    stall_n = 0;

    // Branches: taken to 0x20, then not taken.
    do_reset();
    prog[8'h00] = enc(6'h07, 6'd1, 6'd1, 16'h20);
    prog[8'h20] = enc(6'h07, 6'd2, 6'd1, 16'h40);
    prog[8'h21] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    run_to_halt(200);
    check("beq_pc", pc_out, 64'h21);
    check("beq_retires", ret_times.size(), 64'd2);

    // r0 write discarded, illegal opcode, HALT at pc 2 held.
    do_reset();
    prog[0] = enc(6'h06, 6'd0, 6'd0, 7);
    prog[1] = enc(6'h3F, 6'd3, 6'd1, 2);
    prog[2] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    run_to_halt(200);
    check_reg("r0_zero", 6'd0, 64'd0);
    check_reg("illegal_no_write", 6'd3, 64'd2);
    check("illegal_pulses", ill_cnt, 64'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("hold_halted", halted, 64'd1);
      check("hold_req", imem_req, 64'd0);
      check("hold_pc", pc_out, 64'd2);
    end

    // Performance counters: three NOPs then HALT.
    do_reset();
    prog[3] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    run_to_halt(200);
`ifdef MIPS_PERF_CNT_EN
    check("ret_cnt", ret_cnt, 64'd3);
    // One cycle raising req after reset, then four cycles for each of the four instructions.
    check("cyc_cnt", cyc_cnt, 64'd17);
`else
    check("ret_cnt_tied", ret_cnt, 64'd0);
    check("cyc_cnt_tied", cyc_cnt, 64'd0);
`endif

    // Reset during EXECUTE of the second ADDI must drop its writeback.
    do_reset();
    prog[0] = enc(6'h06, 6'd6, 6'd0, 11);
    prog[1] = enc(6'h06, 6'd6, 6'd0, 9);
    prog[2] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = (imem_req === 1'b1) && (imem_ready === 1'b1) && (imem_addr == 16'd1);
      n++;
    end
    check("fetch1_seen", seen, 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc_out, RstPc);
    check("midrst_req", imem_req, 64'd0);
    check("midrst_retire", retire, 64'd0);
    check("midrst_halted", halted, 64'd0);
    do_reset();
    prog[0] = enc(6'h08, 6'd0, 6'd0, 0);
    release_reset();
    run_to_halt(100);
    check_reg("midrst_r6", 6'd6, 64'd11);
    check("midrst_final_pc", pc_out, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
